// File: rtl/spi_reg_bank.sv
// Register bank behind an SPI byte receiver: a command byte, then a write or read burst.
// Writes land one clk after each received byte; read data is reloaded one clk after each byte.
module spi_reg_bank #(
    parameter int          NREGS     = 16,
    parameter int          TIMEOUT   = 1024,
    parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           data_in,
    input  logic                 received,
    output logic [7:0]           to_output,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 wr_strobe,
    output logic [3:0]           wr_addr,
    output logic                 frame_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [3:0]      addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      out_q, out_d;
    logic            strobe_q, strobe_d;
    logic [3:0]      wr_addr_q, wr_addr_d;
    logic            ferr_q, ferr_d;
    logic            reg_we;
    logic [7:0]      regs_q [NREGS];

    logic            cmd_ok;
    logic            timeout;
    logic [3:0]      addr_p1;

    assign cmd_ok  = (data_in[6:4] == 3'b000);
    assign addr_p1 = addr_q + 4'd1;
    // A byte arriving in the timeout cycle wins: the frame stays open.
    assign timeout = (state_q != IDLE) && !received && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (received) begin
                    if (!cmd_ok)         state_d = DISCARD;
                    else if (data_in[7]) state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            default: begin
                if (timeout) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        ferr_d    = ferr_q;
        reg_we    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (received) begin
                    if (cmd_ok) begin
                        addr_d = data_in[3:0];
                        if (!data_in[7]) out_d = regs_q[data_in[3:0]];
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (received) begin
                    reg_we    = 1'b1;
                    strobe_d  = 1'b1;
                    wr_addr_d = addr_q;
                    addr_d    = addr_p1;
                end
            end
            READ: begin
                if (received) begin
                    addr_d = addr_p1;
                    out_d  = regs_q[addr_p1];
                end
            end
            default: ;
        endcase
        if (state_q != IDLE) begin
            if (received) begin
                cnt_d = '0;
            end else if (timeout) begin
                cnt_d = '0;
                out_d = IDLE_BYTE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= 4'd0;
            cnt_q     <= '0;
            out_q     <= IDLE_BYTE;
            strobe_q  <= 1'b0;
            wr_addr_q <= 4'd0;
            ferr_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
        end else begin
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            ferr_q    <= ferr_d;
            if (reg_we) regs_q[addr_q] <= data_in;
        end
    end

    always_comb begin
        to_output = out_q;
        wr_strobe = strobe_q;
        wr_addr   = wr_addr_q;
        frame_err = ferr_q;
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed frames with literal expectations, then random traffic vs a frame model.
module tb_spi_reg_bank;

    localparam int         NREGS = 16;
    localparam int         TMO   = 16;
    localparam logic [7:0] IDLEB = 8'hA5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [7:0]          data_in = 8'h00;
    logic                received = 1'b0;
    logic [7:0]          to_output;
    logic [8*NREGS-1:0]  regs_flat;
    logic                wr_strobe;
    logic [3:0]          wr_addr;
    logic                frame_err;

    spi_reg_bank #(.NREGS(NREGS), .TIMEOUT(TMO), .IDLE_BYTE(IDLEB)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .received(received),
        .to_output(to_output), .regs_flat(regs_flat), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: mode 0 idle, 1 write burst, 2 read burst, 3 discarding.
    int         m_mode;
    int         m_since;
    logic [3:0] m_addr;
    logic [7:0] m_regs [NREGS];
    logic [7:0] m_out;
    logic       m_str;
    logic [3:0] m_wa;
    logic       m_ferr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_since = 0; m_addr = 0; m_out = IDLEB;
            m_str = 0; m_wa = 0; m_ferr = 0;
            for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        end else begin
            m_str = 0;
            if (m_mode == 0) begin
                if (received) begin
                    if (data_in[6:4] != 3'd0) begin
                        m_ferr = 1; m_mode = 3;
                    end else begin
                        m_addr = data_in[3:0];
                        m_mode = data_in[7] ? 1 : 2;
                        if (!data_in[7]) m_out = m_regs[m_addr];
                    end
                    m_since = 0;
                end
            end else if (received) begin
                m_since = 0;
                if (m_mode == 1) begin
                    m_regs[m_addr] = data_in;
                    m_str = 1; m_wa = m_addr;
                    m_addr = m_addr + 4'd1;
                end else if (m_mode == 2) begin
                    m_addr = m_addr + 4'd1;
                    m_out  = m_regs[m_addr];
                end
            end else begin
                m_since++;
                if (m_since == TMO) begin
                    m_mode = 0; m_since = 0; m_out = IDLEB;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [8*NREGS-1:0] exp_flat;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) exp_flat[8*i +: 8] = m_regs[i];
            chk("model to_output", to_output, m_out);
            chk("model wr_strobe", wr_strobe, m_str);
            chk("model wr_addr",   wr_addr,   m_wa);
            chk("model frame_err", frame_err, m_ferr);
            chk("model regs_flat", regs_flat, exp_flat);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk); data_in = b; received = 1'b1;
        @(negedge clk); received = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
    endtask

    initial begin
        int gap_left;
        int sel;
        logic [7:0] b;
        idle(2);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("reset to_output", to_output, 8'hA5);
        chk("reset regs",      regs_flat, 128'h0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset wr_strobe", wr_strobe, 1'b0);

        send(8'h83);
        send(8'h11);
        chk("wr1 strobe", wr_strobe, 1'b1);
        chk("wr1 addr",   wr_addr,   4'd3);
        chk("wr1 to_output idle", to_output, 8'hA5);
        send(8'h22);
        chk("wr2 strobe", wr_strobe, 1'b1);
        chk("wr2 addr",   wr_addr,   4'd4);
        idle(TMO + 4);
        chk("reg3", regs_flat[8*3 +: 8], 8'h11);
        chk("reg4", regs_flat[8*4 +: 8], 8'h22);

        send(8'h8F); send(8'hAA); send(8'hBB);
        idle(TMO + 4);
        chk("reg15 wrap", regs_flat[8*15 +: 8], 8'hAA);
        chk("reg0 wrap",  regs_flat[8*0 +: 8],  8'hBB);

        send(8'h03);
        chk("rd first", to_output, 8'h11);
        send(8'h00);
        chk("rd second", to_output, 8'h22);
        idle(TMO + 4);
        chk("rd timeout idle byte", to_output, 8'hA5);

        send(8'hF0);
        chk("bad cmd frame_err", frame_err, 1'b1);
        send(8'h55);
        chk("discard no strobe", wr_strobe, 1'b0);
        idle(TMO + 4);
        send(8'h81); send(8'h77);
        idle(2);
        chk("reg1 after discard", regs_flat[8*1 +: 8], 8'h77);
        chk("frame_err sticky", frame_err, 1'b1);
        idle(TMO + 4);

        pulse_reset();
        @(negedge clk);
        chk("post reset frame_err", frame_err, 1'b0);
        send(8'h82);
        idle(TMO + 4);
        send(8'h44);
        chk("timeout then cmd frame_err", frame_err, 1'b1);
        chk("reg2 unchanged", regs_flat[8*2 +: 8], 8'h00);
        idle(TMO + 4);

        pulse_reset();
        send(8'h85);
        pulse_reset();
        send(8'h99);
        chk("midframe reset frame_err", frame_err, 1'b1);
        chk("reg5 unchanged", regs_flat[8*5 +: 8], 8'h00);
        idle(TMO + 4);

        pulse_reset();
        gap_left = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (gap_left == 0) begin
                b = 8'($urandom);
                if ($urandom_range(0, 3) != 0) b[6:4] = 3'b000;
                data_in  = b;
                received = 1'b1;
                sel = int'($urandom_range(0, 9));
                if (sel < 4)      gap_left = 0;
                else if (sel < 7) gap_left = int'($urandom_range(1, 3));
                else              gap_left = int'($urandom_range(TMO - 2, TMO + 1));
            end else begin
                received = 1'b0;
                data_in  = 8'($urandom);
                gap_left--;
            end
        end
        @(negedge clk); received = 1'b0;
        idle(TMO + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter NREGS, 16, number of 8-bit registers; address width is 4 bits, fixed.
REQ-002 SHALL have parameter TIMEOUT, 1024, clk cycles without a received byte before the frame is abandoned.
REQ-003 SHALL have parameter IDLE_BYTE, 8'hA5, value driven on to_output when no read data is pending.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_in  input  8  byte from the upstream SPI receiver.
REQ-007 SHALL have port received  input  1  one-clk pulse; data_in valid in that cycle.
REQ-008 SHALL have port to_output  output  8  byte the SPI receiver shifts out on miso during the next transfer.
REQ-009 SHALL have port regs_flat  output  8*NREGS  register contents; reg[i] at bits [8i+7:8i].
REQ-010 SHALL have port wr_strobe  output  1  one-clk pulse per register write.
REQ-011 SHALL have port wr_addr  output  4  address of the current write; valid with wr_strobe.
REQ-012 SHALL have port frame_err  output  1  sticky; set on a malformed command byte.

Function
REQ-013 SHALL implement states IDLE, WRITE, READ, DISCARD.
REQ-014 SHALL decode the first byte of a frame as a command: bit7 = 1 write / 0 read; bits[3:0] = start address; bits[6:4] reserved.
REQ-015 In IDLE on received with bits[6:4]==0: SHALL latch the address and enter WRITE (bit7=1) or READ (bit7=0).
REQ-016 In IDLE on received with bits[6:4]!=0: SHALL set frame_err and enter DISCARD.
REQ-017 In WRITE on each received: SHALL store data_in into reg[addr], pulse wr_strobe with wr_addr=addr in the following cycle, then increment addr.
REQ-018 On entering READ: SHALL load to_output with reg[start address] one clk after the command pulse.
REQ-019 In READ on each received: SHALL increment addr and load to_output with reg[addr+1] one clk later; incoming data_in is ignored.
REQ-020 SHALL wrap addr from 15 to 0 in both WRITE and READ bursts.
REQ-021 In DISCARD: SHALL ignore all bytes; no register writes.
REQ-022 SHALL count clk cycles since the last received pulse in WRITE, READ and DISCARD; the counter restarts on every received.
REQ-023 When the counter reaches TIMEOUT: SHALL return to IDLE and set to_output to IDLE_BYTE on the next clk.
REQ-024 When received and the timeout coincide in the same cycle: SHALL process the byte in the current state and restart the counter; no transition to IDLE.
REQ-025 In IDLE and WRITE: SHALL drive to_output = IDLE_BYTE.
REQ-026 A received pulse SHALL be consumed exactly once; consecutive-cycle pulses SHALL each be processed.
REQ-027 SHALL leave frame_err set until reset; later valid frames SHALL still be processed.

Reset
REQ-028 On rst low: SHALL asynchronously enter IDLE; all registers 8'h00; addr 0; counter 0; wr_strobe 0; wr_addr 0; frame_err 0; to_output IDLE_BYTE.
REQ-029 Reset asserted mid-frame: SHALL abandon the frame; the first byte after release SHALL be decoded as a command.

Verification
REQ-030 Bytes 8'h83, 8'h11, 8'h22 -> reg3=8'h11, reg4=8'h22; two wr_strobe pulses, wr_addr 3 then 4.
REQ-031 Bytes 8'h8F, 8'hAA, 8'hBB -> reg15=8'hAA, reg0=8'hBB (wrap).
REQ-032 After REQ-030, bytes 8'h03, 8'h00 -> to_output 8'h11 one clk after first pulse, 8'h22 one clk after second.
REQ-033 Byte 8'hF0 then 8'h55 -> frame_err=1, no wr_strobe, registers unchanged; after TIMEOUT idle cycles, 8'h81, 8'h77 -> reg1=8'h77.
REQ-034 Command 8'h82 then no bytes for TIMEOUT cycles, then 8'h44 -> 8'h44 decoded as a command (bit6 set: frame_err=1), reg2 unchanged.
REQ-035 rst pulsed low between 8'h85 and 8'h99 -> reg5 stays 8'h00; 8'h99 decoded as a command (bit4 set: frame_err=1).
